// File: rtl/cache_req_arbiter.sv
// Purpose: two-port (fetch/LSU) arbiter that owns the single cache request channel.
// Latency: grant 1 cycle after a valid is sampled in IDLE; response 1 cycle after cache fulfils.
// Backpressure: one transaction in flight; requesters hold valid until their fulfilled pulse.
// Optional: define CACHE_ARB_ROUND_ROBIN_EN for round-robin contention (default: LSU priority).

package cache_arb_pkg;
    typedef enum logic [1:0] {
        MEM_LOAD  = 2'd0,
        MEM_STORE = 2'd1
    } memory_operation_e;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'd0,
        MEM_SIZE_HALF = 2'd1,
        MEM_SIZE_WORD = 2'd2
    } memory_operation_size_e;
endpackage

module cache_req_arbiter
    import cache_arb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,

    input  logic [XLEN-1:0]        i_req_address,
    input  memory_operation_e      i_req_operation,
    input  memory_operation_size_e i_req_size,
    input  logic [XLEN-1:0]        i_req_store_word,
    input  logic                   i_req_valid,
    output logic [XLEN-1:0]        i_req_loaded_word,
    output logic                   i_req_fulfilled,

    input  logic [XLEN-1:0]        d_req_address,
    input  memory_operation_e      d_req_operation,
    input  memory_operation_size_e d_req_size,
    input  logic [XLEN-1:0]        d_req_store_word,
    input  logic                   d_req_valid,
    output logic [XLEN-1:0]        d_req_loaded_word,
    output logic                   d_req_fulfilled,

    output logic [XLEN-1:0]        c_req_address,
    output memory_operation_e      c_req_operation,
    output memory_operation_size_e c_req_size,
    output logic [XLEN-1:0]        c_req_store_word,
    output logic                   c_req_valid,
    input  logic [XLEN-1:0]        c_req_loaded_word,
    input  logic                   c_req_fulfilled
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    // Owner / last-grant encoding: 0 = fetch port, 1 = LSU port.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic [1:0]             r_state;
    logic                   r_owner;
    logic                   r_last_grant;
    logic [XLEN-1:0]        r_address;
    memory_operation_e      r_operation;
    memory_operation_size_e r_size;
    logic [XLEN-1:0]        r_store_word;
    logic                   r_c_valid;
    logic                   r_i_fulfilled;
    logic                   r_d_fulfilled;
    logic [XLEN-1:0]        r_i_loaded_word;
    logic [XLEN-1:0]        r_d_loaded_word;

    logic                   w_any_valid;
    logic                   w_grant_d;

    // Arbitration decision, only consumed while in IDLE.
    always_comb begin
        w_any_valid = i_req_valid | d_req_valid;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        // On contention the port that did not win last time goes first.
        w_grant_d   = d_req_valid & (~i_req_valid | (r_last_grant == GRANT_I));
`else
        // LSU always beats fetch; fetch wins only when LSU is idle.
        w_grant_d   = d_req_valid;
`endif
    end

    // Transaction FSM: capture winner, hold it toward the cache, return response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_owner         <= GRANT_I;
            r_last_grant    <= GRANT_I;
            r_address       <= '0;
            r_operation     <= MEM_LOAD;
            r_size          <= MEM_SIZE_BYTE;
            r_store_word    <= '0;
            r_c_valid       <= 1'b0;
            r_i_fulfilled   <= 1'b0;
            r_d_fulfilled   <= 1'b0;
            r_i_loaded_word <= '0;
            r_d_loaded_word <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_i_fulfilled <= 1'b0;
                    r_d_fulfilled <= 1'b0;
                    if (w_any_valid) begin
                        r_owner      <= w_grant_d ? GRANT_D : GRANT_I;
                        r_address    <= w_grant_d ? d_req_address    : i_req_address;
                        r_operation  <= w_grant_d ? d_req_operation  : i_req_operation;
                        r_size       <= w_grant_d ? d_req_size       : i_req_size;
                        r_store_word <= w_grant_d ? d_req_store_word : i_req_store_word;
                        r_c_valid    <= 1'b1;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Requester inputs are deliberately not looked at here.
                    if (c_req_fulfilled) begin
                        if (r_owner == GRANT_D) begin
                            r_d_loaded_word <= c_req_loaded_word;
                            r_d_fulfilled   <= 1'b1;
                        end else begin
                            r_i_loaded_word <= c_req_loaded_word;
                            r_i_fulfilled   <= 1'b1;
                        end
                        r_last_grant <= r_owner;
                        r_c_valid    <= 1'b0;
                        r_state      <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    // Fulfilled pulse lasts exactly this one cycle.
                    r_i_fulfilled <= 1'b0;
                    r_d_fulfilled <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_c_valid     <= 1'b0;
                    r_i_fulfilled <= 1'b0;
                    r_d_fulfilled <= 1'b0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign c_req_address     = r_address;
    assign c_req_operation   = r_operation;
    assign c_req_size        = r_size;
    assign c_req_store_word  = r_store_word;
    assign c_req_valid       = r_c_valid;
    assign i_req_loaded_word = r_i_loaded_word;
    assign i_req_fulfilled   = r_i_fulfilled;
    assign d_req_loaded_word = r_d_loaded_word;
    assign d_req_fulfilled   = r_d_fulfilled;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Purpose: directed self-checking bench for cache_req_arbiter (fixed priority or round robin).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: bench plays the cache, stalling fulfilment for chosen cycle counts.

module tb_cache_req_arbiter;
    import cache_arb_pkg::*;

    localparam int XLEN = 32;

    logic                   clk;
    logic                   reset_n;
    logic [XLEN-1:0]        i_req_address;
    memory_operation_e      i_req_operation;
    memory_operation_size_e i_req_size;
    logic [XLEN-1:0]        i_req_store_word;
    logic                   i_req_valid;
    logic [XLEN-1:0]        i_req_loaded_word;
    logic                   i_req_fulfilled;
    logic [XLEN-1:0]        d_req_address;
    memory_operation_e      d_req_operation;
    memory_operation_size_e d_req_size;
    logic [XLEN-1:0]        d_req_store_word;
    logic                   d_req_valid;
    logic [XLEN-1:0]        d_req_loaded_word;
    logic                   d_req_fulfilled;
    logic [XLEN-1:0]        c_req_address;
    memory_operation_e      c_req_operation;
    memory_operation_size_e c_req_size;
    logic [XLEN-1:0]        c_req_store_word;
    logic                   c_req_valid;
    logic [XLEN-1:0]        c_req_loaded_word;
    logic                   c_req_fulfilled;

    int n_checks = 0;
    int n_errors = 0;

    cache_req_arbiter #(.XLEN(XLEN)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .i_req_address     (i_req_address),
        .i_req_operation   (i_req_operation),
        .i_req_size        (i_req_size),
        .i_req_store_word  (i_req_store_word),
        .i_req_valid       (i_req_valid),
        .i_req_loaded_word (i_req_loaded_word),
        .i_req_fulfilled   (i_req_fulfilled),
        .d_req_address     (d_req_address),
        .d_req_operation   (d_req_operation),
        .d_req_size        (d_req_size),
        .d_req_store_word  (d_req_store_word),
        .d_req_valid       (d_req_valid),
        .d_req_loaded_word (d_req_loaded_word),
        .d_req_fulfilled   (d_req_fulfilled),
        .c_req_address     (c_req_address),
        .c_req_operation   (c_req_operation),
        .c_req_size        (c_req_size),
        .c_req_store_word  (c_req_store_word),
        .c_req_valid       (c_req_valid),
        .c_req_loaded_word (c_req_loaded_word),
        .c_req_fulfilled   (c_req_fulfilled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance until the arbiter presents a request, bounded.
    task automatic wait_busy(input string tag);
        int n;
        n = 0;
        while (c_req_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, c_req_valid}, 32'd1);
    endtask

    // Play the cache: stall 'delay' cycles, then fulfil with 'data'. Ends in the RESPOND cycle.
    task automatic serve(input int delay, input logic [31:0] data);
        repeat (delay) tick();
        c_req_fulfilled   = 1'b1;
        c_req_loaded_word = data;
        tick();
        c_req_fulfilled   = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    logic exp_d;
    logic [31:0] exp_addr;

    initial begin
        reset_n = 1'b0;
        i_req_address = '0; i_req_operation = MEM_LOAD; i_req_size = MEM_SIZE_WORD;
        i_req_store_word = '0; i_req_valid = 1'b0;
        d_req_address = '0; d_req_operation = MEM_LOAD; d_req_size = MEM_SIZE_WORD;
        d_req_store_word = '0; d_req_valid = 1'b0;
        c_req_loaded_word = '0; c_req_fulfilled = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_cvalid", {31'd0, c_req_valid}, 32'd0);
        chk("rst_ifulf", {31'd0, i_req_fulfilled}, 32'd0);
        chk("rst_dfulf", {31'd0, d_req_fulfilled}, 32'd0);
        chk("rst_caddr", c_req_address, 32'd0);
        chk("rst_cstore", c_req_store_word, 32'd0);
        chk("rst_cop", {30'd0, c_req_operation}, 32'd0);
        chk("rst_csize", {30'd0, c_req_size}, 32'd0);
        chk("rst_iload", i_req_loaded_word, 32'd0);
        chk("rst_dload", d_req_loaded_word, 32'd0);
        reset_n = 1'b1;

        // Idle window
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_cvalid", {31'd0, c_req_valid}, 32'd0);
            chk("idle_ifulf", {31'd0, i_req_fulfilled}, 32'd0);
            chk("idle_dfulf", {31'd0, d_req_fulfilled}, 32'd0);
        end

        // Stray cache fulfil outside BUSY is ignored
        c_req_fulfilled = 1'b1; c_req_loaded_word = 32'h5555_AAAA;
        tick();
        c_req_fulfilled = 1'b0;
        tick();
        chk("stray_ifulf", {31'd0, i_req_fulfilled}, 32'd0);
        chk("stray_dfulf", {31'd0, d_req_fulfilled}, 32'd0);
        chk("stray_dload", d_req_loaded_word, 32'd0);
        chk("stray_cvalid", {31'd0, c_req_valid}, 32'd0);

        // Single LSU load
        d_req_address = 32'h0000_1000; d_req_operation = MEM_LOAD; d_req_valid = 1'b1;
        tick();
        chk("ld_cvalid_n1", {31'd0, c_req_valid}, 32'd1);
        chk("ld_caddr", c_req_address, 32'h0000_1000);
        chk("ld_cop", {30'd0, c_req_operation}, {30'd0, MEM_LOAD});
        serve(2, 32'hDEAD_BEEF);
        chk("ld_dfulf", {31'd0, d_req_fulfilled}, 32'd1);
        chk("ld_dload", d_req_loaded_word, 32'hDEAD_BEEF);
        chk("ld_ifulf", {31'd0, i_req_fulfilled}, 32'd0);
        chk("ld_iload", i_req_loaded_word, 32'd0);
        chk("ld_cvalid_resp", {31'd0, c_req_valid}, 32'd0);
        d_req_valid = 1'b0;
        tick();
        chk("ld_dfulf_once", {31'd0, d_req_fulfilled}, 32'd0);
        chk("ld_dload_hold", d_req_loaded_word, 32'hDEAD_BEEF);

        // Simultaneous requests after reset (last_grant = I): LSU first either way
        do_reset();
        i_req_address = 32'h100; i_req_valid = 1'b1;
        d_req_address = 32'h200; d_req_valid = 1'b1;
        tick();
        chk("con_first_addr", c_req_address, 32'h200);
        serve(0, 32'h1111_2222);
        chk("con_first_dfulf", {31'd0, d_req_fulfilled}, 32'd1);
        chk("con_first_ifulf", {31'd0, i_req_fulfilled}, 32'd0);
        d_req_valid = 1'b0;
        tick();
        chk("con_gap_cvalid", {31'd0, c_req_valid}, 32'd0);
        tick();
        chk("con_second_cvalid", {31'd0, c_req_valid}, 32'd1);
        chk("con_second_addr", c_req_address, 32'h100);
        serve(1, 32'h3333_4444);
        chk("con_second_ifulf", {31'd0, i_req_fulfilled}, 32'd1);
        chk("con_second_iload", i_req_loaded_word, 32'h3333_4444);
        chk("con_second_dload", d_req_loaded_word, 32'h1111_2222);
        i_req_valid = 1'b0;
        tick();

        // Continuous contention for 6 transactions
        do_reset();
        i_req_valid = 1'b1; d_req_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            exp_addr = exp_d ? 32'h200 : 32'h100;
            wait_busy("rr_wait");
            chk("rr_addr", c_req_address, exp_addr);
            serve(1, 32'hA000_0000 + k);
            chk("rr_dfulf", {31'd0, d_req_fulfilled}, {31'd0, exp_d});
            chk("rr_ifulf", {31'd0, i_req_fulfilled}, {31'd0, ~exp_d});
            tick();
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        tick();

        // Store held stable through a 7-cycle stall, payload changes ignored
        d_req_address = 32'h40; d_req_store_word = 32'hCAFE_0001;
        d_req_operation = MEM_STORE; d_req_size = MEM_SIZE_WORD; d_req_valid = 1'b1;
        tick();
        d_req_address = 32'h44; d_req_store_word = 32'h1234_5678;
        d_req_operation = MEM_LOAD; d_req_size = MEM_SIZE_BYTE;
        for (int j = 0; j < 8; j++) begin
            chk("st_cvalid", {31'd0, c_req_valid}, 32'd1);
            chk("st_addr", c_req_address, 32'h40);
            chk("st_data", c_req_store_word, 32'hCAFE_0001);
            chk("st_op", {30'd0, c_req_operation}, {30'd0, MEM_STORE});
            chk("st_size", {30'd0, c_req_size}, {30'd0, MEM_SIZE_WORD});
            if (j == 7) c_req_fulfilled = 1'b1;
            tick();
        end
        c_req_fulfilled = 1'b0;
        chk("st_dfulf", {31'd0, d_req_fulfilled}, 32'd1);
        d_req_valid = 1'b0; d_req_operation = MEM_LOAD;
        tick();

        // Reset while BUSY drops the request
        d_req_address = 32'h80; d_req_valid = 1'b1;
        tick();
        chk("mid_busy", {31'd0, c_req_valid}, 32'd1);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; d_req_valid = 1'b0;
        chk("mid_cvalid", {31'd0, c_req_valid}, 32'd0);
        chk("mid_dfulf", {31'd0, d_req_fulfilled}, 32'd0);
        chk("mid_caddr", c_req_address, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_nopulse_d", {31'd0, d_req_fulfilled}, 32'd0);
            chk("mid_nopulse_i", {31'd0, i_req_fulfilled}, 32'd0);
        end
        i_req_address = 32'h300; i_req_valid = 1'b1;
        wait_busy("post_wait");
        chk("post_addr", c_req_address, 32'h300);
        serve(2, 32'h0BAD_F00D);
        chk("post_ifulf", {31'd0, i_req_fulfilled}, 32'd1);
        chk("post_iload", i_req_loaded_word, 32'h0BAD_F00D);
        chk("post_dload", d_req_loaded_word, 32'd0);
        i_req_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
